// File: rtl/cpu_pkg.sv
// Shared definitions for the program loader and its CPU-side neighbours:
// loader FSM states, the terminator word and byte-lane geometry.
package cpu_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      FILL  = 3'd3,
      DONE  = 3'd4
   } loader_state_t;

   localparam logic [31:0] NOP_WORD       = 32'h0000_0000;
   localparam int          BYTES_PER_WORD = 4;
   localparam logic [1:0]  LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);

   // True when a word is the program terminator.
   function automatic logic is_nop(input logic [31:0] word);
      return (word == NOP_WORD);
   endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Byte-lane assembler: collects little-endian bytes into a 32-bit word.
// The fourth byte is not stored; it is merged combinationally so the parent
// can register the complete word on the same edge that accepts that byte.
module loader_word_assembler
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_accept,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [23:0] lanes_r;
   logic [1:0]  byte_idx_r;

   // Store the lower three lanes and advance the lane index per accepted byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         lanes_r    <= 24'h00_0000;
         byte_idx_r <= 2'd0;
      end else if (clear) begin
         lanes_r    <= 24'h00_0000;
         byte_idx_r <= 2'd0;
      end else if (byte_accept) begin
         case (byte_idx_r)
            2'd0:    lanes_r[7:0]   <= byte_data;
            2'd1:    lanes_r[15:8]  <= byte_data;
            2'd2:    lanes_r[23:16] <= byte_data;
            default: lanes_r        <= lanes_r;
         endcase
         byte_idx_r <= byte_idx_r + 2'd1;
      end
   end

   // Word completes when the last lane's byte is being accepted.
   always_comb begin
      word_valid = byte_accept && (byte_idx_r == LAST_BYTE_IDX);
      word       = {byte_data, lanes_r};
   end

endmodule

// File: rtl/imem_loader.sv
// Program loader for cpu_sequential: streams bytes into 32-bit words, writes
// them to instruction memory from address 0 and releases the CPU reset once
// the all-zero terminator word has been written.
// Optional feature macro: IMEM_LOADER_ZERO_FILL_EN -- zero the rest of memory
// after the terminator before releasing the CPU.
module imem_loader
   import cpu_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int ADDR_W      = 6
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W:0]   word_count
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_WORDS - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   loader_state_t     state_r;
   loader_state_t     state_nxt_s;
   logic [ADDR_W-1:0] addr_nxt_s;
   logic [ADDR_W:0]   count_nxt_s;
   logic              we_nxt_s;
   logic [31:0]       wdata_nxt_s;
   logic              overflow_nxt_s;
   logic              clear_s;
   logic              accept_s;
   logic              word_valid_s;
   logic [31:0]       word_s;

   loader_word_assembler u_asm (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear_s),
      .byte_accept (accept_s),
      .byte_data   (byte_data),
      .word_valid  (word_valid_s),
      .word        (word_s)
   );

   // Next-state and next-output decode; every output is registered below.
   always_comb begin
      state_nxt_s    = state_r;
      addr_nxt_s     = imem_addr;
      count_nxt_s    = word_count;
      we_nxt_s       = 1'b0;
      wdata_nxt_s    = imem_wdata;
      overflow_nxt_s = overflow;
      clear_s        = 1'b0;
      accept_s       = (state_r == RECV) && byte_valid && byte_ready;

      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               state_nxt_s    = RECV;
               addr_nxt_s     = '0;
               count_nxt_s    = '0;
               overflow_nxt_s = 1'b0;
               clear_s        = 1'b1;
            end else begin
               state_nxt_s = state_r;
            end
         end
         RECV: begin
            if (word_valid_s) begin
               state_nxt_s = WRITE;
               we_nxt_s    = 1'b1;
               wdata_nxt_s = word_s;
            end else begin
               state_nxt_s = RECV;
            end
         end
         WRITE: begin
            count_nxt_s = word_count + CNT_ONE;
            if (is_nop(imem_wdata)) begin
`ifdef IMEM_LOADER_ZERO_FILL_EN
               if (imem_addr == LAST_ADDR) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = FILL;
                  addr_nxt_s  = imem_addr + ADDR_ONE;
                  we_nxt_s    = 1'b1;
                  wdata_nxt_s = NOP_WORD;
               end
`else
               state_nxt_s = DONE;
`endif
            end else if (imem_addr == LAST_ADDR) begin
               // Memory full and still no terminator: stop, never wrap.
               state_nxt_s    = DONE;
               overflow_nxt_s = 1'b1;
            end else begin
               state_nxt_s = RECV;
               addr_nxt_s  = imem_addr + ADDR_ONE;
            end
         end
         FILL: begin
`ifdef IMEM_LOADER_ZERO_FILL_EN
            if (imem_addr == LAST_ADDR) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = FILL;
               addr_nxt_s  = imem_addr + ADDR_ONE;
               we_nxt_s    = 1'b1;
               wdata_nxt_s = NOP_WORD;
            end
`else
            // Unreachable without zero fill; recover to a safe state.
            state_nxt_s = IDLE;
`endif
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State and output registers, derived from the decoded next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         byte_ready <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'h0000_0000;
         cpu_reset  <= 1'b1;
         done       <= 1'b0;
         overflow   <= 1'b0;
         word_count <= '0;
      end else begin
         state_r    <= state_nxt_s;
         byte_ready <= (state_nxt_s == RECV);
         imem_we    <= we_nxt_s;
         imem_addr  <= addr_nxt_s;
         imem_wdata <= wdata_nxt_s;
         cpu_reset  <= (state_nxt_s != DONE);
         done       <= (state_nxt_s == DONE);
         overflow   <= overflow_nxt_s;
         word_count <= count_nxt_s;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: terminated program,
// back-pressure, restart from DONE, reset mid-word and overflow.
// Honours IMEM_LOADER_ZERO_FILL_EN for the expected write counts.
module tb_imem_loader;

   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_reset;
   logic          done;
   logic          overflow;
   logic [AW:0]   word_count;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0]   mem [0:DEPTH-1] = '{default: 32'hDEAD_BEEF};
   int            wr_cnt    = 0;
   int            clash_cnt = 0;
   logic [AW-1:0] last_addr = '0;
   logic [7:0]    acc_q [$];

   logic [7:0] prog [12] = '{8'h13, 8'h03, 8'ha0, 8'h00,
                             8'h93, 8'h03, 8'h00, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h00};

   always #5 clk = ~clk;

   imem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .done       (done),
      .overflow   (overflow),
      .word_count (word_count)
   );

   // Memory model, accepted-byte log and write/ready overlap monitor.
   always @(posedge clk) begin
      if (imem_we) begin
         mem[imem_addr] <= imem_wdata;
         wr_cnt         <= wr_cnt + 1;
         last_addr      <= imem_addr;
      end
      if (byte_valid && byte_ready) acc_q.push_back(byte_data);
      if (imem_we && byte_ready) clash_cnt <= clash_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int waited = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && waited < 20) begin
         tick();
         waited++;
      end
      chk("byte_ready_wait", {31'd0, byte_ready}, 32'd1);
      tick();
      if (gap) begin
         byte_valid = 1'b0;
         byte_data  = 8'hEE;
         tick();
      end
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
   endtask

   task automatic wait_done();
      int n = 0;
      byte_valid = 1'b0;
      while (!done && n < 200) begin
         tick();
         n++;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
      chk("cpu_reset_low_with_done", {31'd0, cpu_reset}, 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
      chk({tag, "_imem_we"},    {31'd0, imem_we},    32'd0);
      chk({tag, "_imem_addr"},  32'(imem_addr),      32'd0);
      chk({tag, "_imem_wdata"}, imem_wdata,          32'h0);
      chk({tag, "_cpu_reset"},  {31'd0, cpu_reset},  32'd1);
      chk({tag, "_done"},       {31'd0, done},       32'd0);
      chk({tag, "_overflow"},   {31'd0, overflow},   32'd0);
      chk({tag, "_word_count"}, 32'(word_count),     32'd0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int wr_base;
      int acc_base;

      reset      = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      tick();
      tick();
      check_reset_values("rst");
      reset = 1'b0;

      // Idle: a valid byte without start is never consumed.
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      tick();
      tick();
      tick();
      chk("idle_no_accept", acc_q.size(), 32'd0);
      check_reset_values("idle");
      byte_valid = 1'b0;

      // Terminated program, byte_valid held high.
      wr_base = wr_cnt;
      pulse_start();
      chk("start_ready", {31'd0, byte_ready}, 32'd1);
      send_word(32'h00a0_0313, 1'b0);
      chk("w0_we",    {31'd0, imem_we},    32'd1);
      chk("w0_addr",  32'(imem_addr),      32'd0);
      chk("w0_wdata", imem_wdata,          32'h00a0_0313);
      chk("w0_ready", {31'd0, byte_ready}, 32'd0);
      send_word(32'h0000_0393, 1'b0);
      send_word(32'h0000_0000, 1'b0);
      wait_done();
      chk("t1_mem0",     mem[0],           32'h00a0_0313);
      chk("t1_mem1",     mem[1],           32'h0000_0393);
      chk("t1_mem2",     mem[2],           32'h0000_0000);
      chk("t1_count",    32'(word_count),  32'd3);
      chk("t1_overflow", {31'd0, overflow}, 32'd0);
`ifdef IMEM_LOADER_ZERO_FILL_EN
      chk("t1_writes",   wr_cnt - wr_base, 32'd64);
      chk("t1_mem3",     mem[3],           32'h0);
      chk("t1_mem63",    mem[63],          32'h0);
      chk("t1_last",     32'(last_addr),   32'd63);
`else
      chk("t1_writes",   wr_cnt - wr_base, 32'd3);
      chk("t1_mem3",     mem[3],           32'hDEAD_BEEF);
      chk("t1_last",     32'(last_addr),   32'd2);
`endif

      // Restart from DONE, then the same stream with back-pressure.
      tick();
      chk("t1_done_hold", {31'd0, done}, 32'd1);
      pulse_start();
      chk("rs_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("rs_done",      {31'd0, done},      32'd0);
      chk("rs_ready",     {31'd0, byte_ready}, 32'd1);
      chk("rs_count",     32'(word_count),    32'd0);
      chk("rs_addr",      32'(imem_addr),     32'd0);
      wr_base  = wr_cnt;
      acc_base = acc_q.size();
      for (int i = 0; i < 12; i++) send_byte(prog[i], 1'b1);
      wait_done();
      chk("bp_accepted", acc_q.size() - acc_base, 32'd12);
      for (int i = 0; i < 12; i++) chk("bp_byte", {24'd0, acc_q[acc_base + i]}, {24'd0, prog[i]});
      chk("bp_mem0",  mem[0],          32'h00a0_0313);
      chk("bp_mem1",  mem[1],          32'h0000_0393);
      chk("bp_mem2",  mem[2],          32'h0000_0000);
      chk("bp_count", 32'(word_count), 32'd3);
      chk("bp_clash", clash_cnt,       32'd0);
`ifdef IMEM_LOADER_ZERO_FILL_EN
      chk("bp_writes", wr_cnt - wr_base, 32'd64);
`else
      chk("bp_writes", wr_cnt - wr_base, 32'd3);
`endif

      // Reset after two bytes of a word: partial bytes must be discarded.
      pulse_start();
      send_byte(8'haa, 1'b0);
      send_byte(8'hbb, 1'b0);
      byte_valid = 1'b0;
      reset      = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_values("midrst");
      tick();
      check_reset_values("midrst_idle");
      wr_base = wr_cnt;
      pulse_start();
      send_word(32'h1122_3344, 1'b0);
      chk("mr_wdata", imem_wdata, 32'h1122_3344);
      send_word(32'h0000_0000, 1'b0);
      wait_done();
      chk("mr_mem0",  mem[0],          32'h1122_3344);
      chk("mr_mem1",  mem[1],          32'h0000_0000);
      chk("mr_count", 32'(word_count), 32'd2);
`ifdef IMEM_LOADER_ZERO_FILL_EN
      chk("mr_writes", wr_cnt - wr_base, 32'd64);
`else
      chk("mr_writes", wr_cnt - wr_base, 32'd2);
`endif

      // Overflow: 64 non-zero words with no terminator.
      wr_base = wr_cnt;
      pulse_start();
      for (int w = 0; w < 64; w++) send_word(32'h0000_0013, 1'b0);
      wait_done();
      chk("of_overflow", {31'd0, overflow}, 32'd1);
      chk("of_count",    32'(word_count),   32'd64);
      chk("of_last",     32'(last_addr),    32'd63);
      chk("of_mem63",    mem[63],           32'h0000_0013);
      chk("of_mem0",     mem[0],            32'h0000_0013);
      chk("of_writes",   wr_cnt - wr_base,  32'd64);
      chk("of_addr",     32'(imem_addr),    32'd63);
      tick();
      chk("of_ready_low", {31'd0, byte_ready}, 32'd0);
      pulse_start();
      chk("of_clear", {31'd0, overflow}, 32'd0);
      chk("of_clear_done", {31'd0, done}, 32'd0);
      chk("final_clash", clash_cnt, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
